// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared widths and entry type for the 8x8 register file write path
// Rev     : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rnum;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/wb_fwd_match.sv
// ============================================================================
// Module  : wb_fwd_match
// Brief   : Youngest-match search over an age-ordered list (index 0 = oldest)
// Rev     : 1.0
// ============================================================================
`default_nettype none

module wb_fwd_match #(
    parameter int N      = 5,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0]         i_rd_num,
    input  logic [N-1:0]              i_vld,
    input  logic [N-1:0][ADDR_W-1:0]  i_reg,
    input  logic [N-1:0][DATA_W-1:0]  i_data,
    output logic                      o_hit,
    output logic [DATA_W-1:0]         o_data
);

    // Later indices are younger, so the last match in the scan wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vld[i] && (i_reg[i] == i_rd_num)) begin
                o_hit  = 1'b1;
                o_data = i_data[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_writeback_queue.sv
// ============================================================================
// Module  : regfile_writeback_queue
// Brief   : Buffered register-file write master with read-port forwarding
// Rev     : 1.0
// ============================================================================
`default_nettype none

module regfile_writeback_queue #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_reg,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         drain_en,
    input  logic                         flush,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_reg,
    output logic [DATA_W-1:0]            wr_data,
    input  logic [ADDR_W-1:0]            rd_num_1,
    input  logic [ADDR_W-1:0]            rd_num_2,
    output logic                         fwd_hit_1,
    output logic [DATA_W-1:0]            fwd_data_1,
    output logic                         fwd_hit_2,
    output logic [DATA_W-1:0]            fwd_data_2,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_N = DEPTH + 1;

    logic [ADDR_W-1:0] r_mem_reg  [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_reg;
    logic [DATA_W-1:0] r_wr_data;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_push = in_valid && !w_full && !flush;
    assign w_pop  = drain_en && (r_count != '0) && !flush;

    // Entry storage is never reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_reg[r_tail]  <= in_reg;
            r_mem_data[r_tail] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wr_en <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head    <= r_head + PTR_W'(1);
                r_wr_reg  <= r_mem_reg[r_head];
                r_wr_data <= r_mem_data[r_head];
            end
            r_wr_en <= w_pop;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Age-ordered view: slot 0 is the output stage, then queue oldest..newest.
    logic [AGE_N-1:0]             w_age_vld;
    logic [AGE_N-1:0][ADDR_W-1:0] w_age_reg;
    logic [AGE_N-1:0][DATA_W-1:0] w_age_data;

    assign w_age_vld[0]  = r_wr_en;
    assign w_age_reg[0]  = r_wr_reg;
    assign w_age_data[0] = r_wr_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [PTR_W-1:0] w_idx;
        assign w_idx            = r_head + PTR_W'(k);
        assign w_age_vld[k+1]   = (CNT_W'(k) < r_count);
        assign w_age_reg[k+1]   = r_mem_reg[w_idx];
        assign w_age_data[k+1]  = r_mem_data[w_idx];
    end

    wb_fwd_match #(.N(AGE_N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_1 (
        .i_rd_num (rd_num_1),
        .i_vld    (w_age_vld),
        .i_reg    (w_age_reg),
        .i_data   (w_age_data),
        .o_hit    (fwd_hit_1),
        .o_data   (fwd_data_1)
    );

    wb_fwd_match #(.N(AGE_N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_2 (
        .i_rd_num (rd_num_2),
        .i_vld    (w_age_vld),
        .i_reg    (w_age_reg),
        .i_data   (w_age_data),
        .o_hit    (fwd_hit_2),
        .o_data   (fwd_data_2)
    );

    assign in_ready = !w_full;
    assign wr_en    = r_wr_en;
    assign wr_reg   = r_wr_reg;
    assign wr_data  = r_wr_data;
    assign count    = r_count;
    assign empty    = (r_count == '0) && !r_wr_en;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
// ============================================================================
// Module  : tb_regfile_writeback_queue
// Brief   : Directed self-checking bench for regfile_writeback_queue
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_writeback_queue;
    import regfile_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [2:0]       in_reg;
    logic [7:0]       in_data;
    logic             drain_en, flush;
    logic             wr_en;
    logic [2:0]       wr_reg;
    logic [7:0]       wr_data;
    logic [2:0]       rd_num_1, rd_num_2;
    logic             fwd_hit_1, fwd_hit_2;
    logic [7:0]       fwd_data_1, fwd_data_2;
    logic [2:0]       count;
    logic             empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .drain_en(drain_en), .flush(flush),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_num_1(rd_num_1), .rd_num_2(rd_num_2),
        .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
        .fwd_hit_2(fwd_hit_2), .fwd_data_2(fwd_data_2),
        .count(count), .empty(empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input wb_entry_t e);
        in_valid = 1'b1;
        in_reg   = e.rnum;
        in_data  = e.data;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
        drain_en = 1'b0; flush = 1'b0; rd_num_1 = '0; rd_num_2 = '0;
        #12;
        total++; if (wr_en !== 1'b0 || wr_reg !== 3'd0 || wr_data !== 8'h00) begin
            bad++; $display("FAIL reset_out got=%b/%0d/%h want=0/0/00", wr_en, wr_reg, wr_data); end
        total++; if (count !== 3'd0 || in_ready !== 1'b1 || empty !== 1'b1) begin
            bad++; $display("FAIL reset_flags count=%0d ready=%b empty=%b want 0/1/1", count, in_ready, empty); end
        #10 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drain_en = 1'b1;
        push('{rnum: 3'd3, data: 8'h5A});
        total++; if (wr_en !== 1'b0 || count !== 3'd1) begin
            bad++; $display("FAIL single_nobypass wr_en=%b count=%0d want 0/1", wr_en, count); end
        tick();
        total++; if (wr_en !== 1'b1 || wr_reg !== 3'd3 || wr_data !== 8'h5A) begin
            bad++; $display("FAIL single_issue got=%b/%0d/%h want=1/3/5a", wr_en, wr_reg, wr_data); end
        total++; if (empty !== 1'b0 || count !== 3'd0) begin
            bad++; $display("FAIL single_busy empty=%b count=%0d want 0/0", empty, count); end
        tick();
        total++; if (wr_en !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL single_idle wr_en=%b empty=%b want 0/1", wr_en, empty); end
        drain_en = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) push('{rnum: 3'(i), data: 8'(i * 8'h11)});
        total++; if (count !== 3'd4 || in_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full count=%0d ready=%b want 4/0", count, in_ready); end
        push('{rnum: 3'd7, data: 8'h77});
        total++; if (count !== 3'd4) begin
            bad++; $display("FAIL fill_refuse count=%0d want 4", count); end
        drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (wr_en !== 1'b1 || wr_reg !== 3'(i) || wr_data !== 8'(i * 8'h11)) begin
                bad++; $display("FAIL drain_order%0d got=%b/%0d/%h want=1/%0d/%h",
                                i, wr_en, wr_reg, wr_data, i, 8'(i * 8'h11)); end
        end
        tick();
        total++; if (wr_en !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL drain_end wr_en=%b empty=%b want 0/1", wr_en, empty); end
        drain_en = 1'b0;
    endtask

    task automatic test_forward();
        push('{rnum: 3'd5, data: 8'hAA});
        push('{rnum: 3'd5, data: 8'hBB});
        rd_num_1 = 3'd5; rd_num_2 = 3'd6;
        #1;
        total++; if (fwd_hit_1 !== 1'b1 || fwd_data_1 !== 8'hBB) begin
            bad++; $display("FAIL fwd_youngest got=%b/%h want=1/bb", fwd_hit_1, fwd_data_1); end
        total++; if (fwd_hit_2 !== 1'b0 || fwd_data_2 !== 8'h00) begin
            bad++; $display("FAIL fwd_miss got=%b/%h want=0/00", fwd_hit_2, fwd_data_2); end
        in_valid = 1'b1; in_reg = 3'd6; in_data = 8'h66;
        #1;
        total++; if (fwd_hit_2 !== 1'b0) begin
            bad++; $display("FAIL fwd_incycle got=%b want=0", fwd_hit_2); end
        tick();
        in_valid = 1'b0;
        total++; if (fwd_hit_2 !== 1'b1 || fwd_data_2 !== 8'h66) begin
            bad++; $display("FAIL fwd_queued got=%b/%h want=1/66", fwd_hit_2, fwd_data_2); end
        drain_en = 1'b1;
        tick();
        total++; if (fwd_hit_1 !== 1'b1 || fwd_data_1 !== 8'hBB) begin
            bad++; $display("FAIL fwd_over_stage got=%b/%h want=1/bb", fwd_hit_1, fwd_data_1); end
        tick();
        tick();
        total++; if (fwd_hit_1 !== 1'b0 || fwd_data_1 !== 8'h00 || fwd_hit_2 !== 1'b1 || fwd_data_2 !== 8'h66) begin
            bad++; $display("FAIL fwd_stage got=%b/%h %b/%h want=0/00 1/66",
                            fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2); end
        drain_en = 1'b0;
        tick();
        total++; if (fwd_hit_2 !== 1'b0 || wr_en !== 1'b0) begin
            bad++; $display("FAIL fwd_clear hit=%b wr_en=%b want 0/0", fwd_hit_2, wr_en); end
    endtask

    task automatic test_full_pushpop();
        for (int i = 1; i <= 4; i++) push('{rnum: 3'(i), data: 8'(i)});
        in_valid = 1'b1; in_reg = 3'd7; in_data = 8'h77; drain_en = 1'b1;
        tick();
        in_valid = 1'b0; drain_en = 1'b0;
        total++; if (wr_en !== 1'b1 || wr_reg !== 3'd1 || count !== 3'd3 || in_ready !== 1'b1) begin
            bad++; $display("FAIL fullpp got=%b/%0d count=%0d ready=%b want=1/1 3 1",
                            wr_en, wr_reg, count, in_ready); end
        drain_en = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            total++; if (wr_en !== 1'b1 || wr_reg !== 3'(i) || wr_data !== 8'(i)) begin
                bad++; $display("FAIL fullpp_drain%0d got=%b/%0d/%h want=1/%0d/%h",
                                i, wr_en, wr_reg, wr_data, i, 8'(i)); end
        end
        tick();
        total++; if (wr_en !== 1'b0) begin
            bad++; $display("FAIL fullpp_refused got=%b/%0d want=0", wr_en, wr_reg); end
        drain_en = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) push('{rnum: 3'(i), data: 8'(8'hA0 + i)});
        flush = 1'b1; in_valid = 1'b1; in_reg = 3'd6; in_data = 8'h66; drain_en = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (count !== 3'd0 || wr_en !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL flush_state count=%0d wr_en=%b empty=%b want 0/0/1", count, wr_en, empty); end
        tick();
        total++; if (wr_en !== 1'b0) begin
            bad++; $display("FAIL flush_nowrite got=%b/%0d want=0", wr_en, wr_reg); end
        drain_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        push('{rnum: 3'd2, data: 8'h12});
        push('{rnum: 3'd3, data: 8'h13});
        drain_en = 1'b1; rd_num_1 = 3'd3;
        tick();
        drain_en = 1'b0;
        total++; if (wr_en !== 1'b1 || count !== 3'd1 || fwd_hit_1 !== 1'b1 || fwd_data_1 !== 8'h13) begin
            bad++; $display("FAIL rstmid_pre wr_en=%b count=%0d hit=%b/%h want 1/1/1/13",
                            wr_en, count, fwd_hit_1, fwd_data_1); end
        #2 reset = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0 || count !== 3'd0 || fwd_hit_1 !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL rstmid_async wr_en=%b count=%0d hit=%b empty=%b want 0/0/0/1",
                            wr_en, count, fwd_hit_1, empty); end
        #3 reset = 1'b1;
        drain_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (wr_en !== 1'b0) begin
                bad++; $display("FAIL rstmid_after%0d got=%b/%0d want=0", i, wr_en, wr_reg); end
        end
        drain_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_forward();
        test_full_pushpop();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
